// File: rtl/decode_stage.sv
// decode_stage: RV64I decode stage.
//   Decodes InstrD from IF/ID, holds the NREG x XLEN register file with
//   write-through bypass, resolves branches/jumps combinationally for fetch,
//   and launches decoded control and operands into the ID/EX register.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   InstrD, PCD, PCPlus4D     IF/ID instruction, its PC and PC+4
//   StallD, FlushE            hold / bubble the ID/EX register
//   RegWriteW, RdW, ResultW   writeback port into the register file
//   PCSrcD, JalD, PCTargetD   combinational redirect to fetch
//   *E outputs                registered ID/EX control, operands, indices
module decode_stage #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            StallD,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcD,
   output logic            JalD,
   output logic [XLEN-1:0] PCTargetD,
   output logic            RegWriteE,
   output logic            MemReadE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic            WordOpE,
   output logic [1:0]      ResultSrcE,
   output logic [3:0]      ALUCtrlE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            IllegalE
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_R32    = 7'b0111011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_I32    = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src;
      logic            word_op;
      logic [1:0]      result_src;
      logic [3:0]      alu_ctrl;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            illegal;
   } idex_t;

   // funct3 -> ALU op; only register-register forms may select SUB via bit 30.
   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic b30,
                                         input logic sub_ok);
      logic [3:0] c;
      case (f3)
         3'd0:    c = (sub_ok && b30) ? 4'd1 : 4'd0;
         3'd1:    c = 4'd2;
         3'd2:    c = 4'd3;
         3'd3:    c = 4'd4;
         3'd4:    c = 4'd5;
         3'd5:    c = b30 ? 4'd7 : 4'd6;
         3'd6:    c = 4'd8;
         default: c = 4'd9;
      endcase
      return c;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
      logic t;
      case (f3)
         3'b000:  t = (a == b);
         3'b001:  t = (a != b);
         3'b100:  t = ($signed(a) <  $signed(b));
         3'b101:  t = ($signed(a) >= $signed(b));
         3'b110:  t = (a <  b);
         3'b111:  t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   logic [XLEN-1:0] r_rf [NREG];
   idex_t           r_idex;
   idex_t           w_dec;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0] w_rd1, w_rd2;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_jalr_sum;
   logic            w_is_branch, w_is_jal, w_is_jalr;

   assign w_opcode = InstrD[6:0];
   assign w_rd     = InstrD[11:7];
   assign w_funct3 = InstrD[14:12];
   assign w_rs1    = InstrD[19:15];
   assign w_rs2    = InstrD[24:20];

   assign w_imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
   assign w_imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
   assign w_imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                     InstrD[11:8], 1'b0};
   assign w_imm_u = {{(XLEN-32){InstrD[31]}}, InstrD[31:12], 12'b0};
   assign w_imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                     InstrD[30:21], 1'b0};

   // Register file: x0 never written; same-cycle writeback bypasses the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      end else if (RegWriteW && (RdW != 5'd0)) begin
         r_rf[RdW] <= ResultW;
      end
   end

   assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                  (RegWriteW && (RdW == w_rs1)) ? ResultW : r_rf[w_rs1];
   assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                  (RegWriteW && (RdW == w_rs2)) ? ResultW : r_rf[w_rs2];

   // ---- Decode (combinational, IF/ID -> ID) ----
   always_comb begin
      w_dec       = '0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      w_dec.rd1   = w_rd1;
      w_dec.rd2   = w_rd2;
      w_dec.pc    = PCD;
      w_dec.pc4   = PCPlus4D;
      w_dec.rs1   = w_rs1;
      w_dec.rs2   = w_rs2;
      w_dec.rd    = w_rd;
      case (w_opcode)
         OP_R, OP_R32: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_ctrl  = alu_op(w_funct3, InstrD[30], 1'b1);
            w_dec.word_op   = (w_opcode == OP_R32);
         end
         OP_I, OP_I32: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.imm       = w_imm_i;
            w_dec.alu_ctrl  = alu_op(w_funct3, InstrD[30], 1'b0);
            w_dec.word_op   = (w_opcode == OP_I32);
         end
         OP_LOAD: begin
            w_dec.reg_write  = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.alu_src    = 1'b1;
            w_dec.imm        = w_imm_i;
            w_dec.result_src = 2'b01;
         end
         OP_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.imm       = w_imm_s;
         end
         OP_LUI, OP_AUIPC: begin
            w_dec.reg_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.imm       = w_imm_u;
            w_dec.alu_ctrl  = (w_opcode == OP_LUI) ? 4'd10 : 4'd11;
         end
         OP_JAL: begin
            w_is_jal         = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_dec.imm        = w_imm_j;
            w_dec.result_src = 2'b10;
         end
         OP_JALR: begin
            if (w_funct3 == 3'b000) begin
               w_is_jalr        = 1'b1;
               w_dec.reg_write  = 1'b1;
               w_dec.alu_src    = 1'b1;
               w_dec.imm        = w_imm_i;
               w_dec.result_src = 2'b10;
            end else begin
               w_dec.illegal = 1'b1;
            end
         end
         OP_BRANCH: begin
            // funct3 010/011 are unassigned branch encodings
            if (w_funct3[2:1] == 2'b01) begin
               w_dec.illegal = 1'b1;
            end else begin
               w_is_branch = 1'b1;
               w_dec.imm   = w_imm_b;
            end
         end
         default: w_dec.illegal = 1'b1;
      endcase
      if (w_rd == 5'd0) w_dec.reg_write = 1'b0;
   end

   // ---- Redirect (combinational, back to fetch) ----
   assign w_jalr_sum = w_rd1 + w_imm_i;
   assign PCSrcD     = w_is_branch & br_taken(w_funct3, w_rd1, w_rd2);
   assign JalD       = w_is_jal | w_is_jalr;
   assign PCTargetD  = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} :
                       w_is_jal  ? (PCD + w_imm_j) : (PCD + w_imm_b);

   // ---- ID/EX register (ID -> EX); flush outranks stall ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idex <= '0;
      end else if (FlushE) begin
         r_idex <= '0;
      end else if (!StallD) begin
         r_idex <= w_dec;
      end
   end

   assign RegWriteE  = r_idex.reg_write;
   assign MemReadE   = r_idex.mem_read;
   assign MemWriteE  = r_idex.mem_write;
   assign ALUSrcE    = r_idex.alu_src;
   assign WordOpE    = r_idex.word_op;
   assign ResultSrcE = r_idex.result_src;
   assign ALUCtrlE   = r_idex.alu_ctrl;
   assign RD1E       = r_idex.rd1;
   assign RD2E       = r_idex.rd2;
   assign ImmExtE    = r_idex.imm;
   assign PCE        = r_idex.pc;
   assign PCPlus4E   = r_idex.pc4;
   assign Rs1E       = r_idex.rs1;
   assign Rs2E       = r_idex.rs2;
   assign RdE        = r_idex.rd;
   assign IllegalE   = r_idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: bench for the RV64I decode stage.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] InstrD;
   logic [63:0] PCD, PCPlus4D;
   logic        StallD, FlushE, RegWriteW;
   logic [4:0]  RdW;
   logic [63:0] ResultW;
   logic        PCSrcD, JalD;
   logic [63:0] PCTargetD;
   logic        RegWriteE, MemReadE, MemWriteE, ALUSrcE, WordOpE, IllegalE;
   logic [1:0]  ResultSrcE;
   logic [3:0]  ALUCtrlE;
   logic [63:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]  Rs1E, Rs2E, RdE;

   decode_stage #(.XLEN(64), .NREG(32)) dut (
      .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .StallD(StallD), .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW),
      .ResultW(ResultW), .PCSrcD(PCSrcD), .JalD(JalD), .PCTargetD(PCTargetD),
      .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .WordOpE(WordOpE), .ResultSrcE(ResultSrcE),
      .ALUCtrlE(ALUCtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
      .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .IllegalE(IllegalE)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        reg_write, mem_read, mem_write, alu_src, word_op;
      logic [1:0]  result_src;
      logic [3:0]  alu_ctrl;
      logic [63:0] rd1, rd2, imm, pc, pc4;
      logic [4:0]  rs1, rs2, rd;
      logic        illegal;
   } e_t;

   typedef enum {K_R, K_I, K_LOAD, K_STORE, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_BAD} kind_t;

   e_t act;
   assign act = {RegWriteE, MemReadE, MemWriteE, ALUSrcE, WordOpE, ResultSrcE, ALUCtrlE,
                 RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, IllegalE};

   int          n_cmp = 0;
   int          n_fail = 0;
   e_t          exp_e;
   logic        x_pcsrc, x_jal;
   logic [63:0] x_tgt;
   logic [63:0] model_rf [32];
   int          alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

   // Architectural register state as seen by the rest of the pipeline.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) model_rf[i] = 64'd0;
      end else if (RegWriteW && RdW != 5'd0) begin
         model_rf[RdW] = ResultW;
      end
   end

   function automatic logic [63:0] rd_model(input logic [4:0] r);
      if (r == 5'd0) return 64'd0;
      if (RegWriteW && RdW == r) return ResultW;
      return model_rf[r];
   endfunction

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   // Reference decode: instruction class first, then each field from its rule.
   function automatic void model(input logic [31:0] ins, input logic [63:0] pc,
         input logic [63:0] pc4, output logic pcsrc, output logic jal,
         output logic [63:0] tgt, output e_t e);
      logic [6:0]  op;
      logic [2:0]  f3;
      longint      sx;
      logic [63:0] iI, iS, iB, iU, iJ, a, b;
      kind_t       k;
      logic        taken;
      int          ac;
      op = ins[6:0];
      f3 = ins[14:12];
      sx = longint'($signed(ins));
      iI = 64'(sx >>> 20);
      iS = 64'((sx >>> 25) <<< 5) | 64'(ins[11:7]);
      iB = 64'((sx >>> 31) <<< 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      iU = 64'((sx >>> 12) <<< 12);
      iJ = 64'((sx >>> 31) <<< 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      a = rd_model(ins[19:15]);
      b = rd_model(ins[24:20]);
      case (op)
         7'b0110011, 7'b0111011: k = K_R;
         7'b0010011, 7'b0011011: k = K_I;
         7'b0000011: k = K_LOAD;
         7'b0100011: k = K_STORE;
         7'b0110111: k = K_LUI;
         7'b0010111: k = K_AUIPC;
         7'b1101111: k = K_JAL;
         7'b1100111: k = (f3 == 3'd0) ? K_JALR : K_BAD;
         7'b1100011: k = (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
         default:    k = K_BAD;
      endcase
      e = '0;
      e.rd1 = a; e.rd2 = b; e.pc = pc; e.pc4 = pc4;
      e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      case (k)
         K_R: begin
            ac = alu_tab[f3] + ((ins[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0);
            e.reg_write = 1; e.alu_ctrl = 4'(ac); e.word_op = (op == 7'b0111011);
         end
         K_I: begin
            ac = alu_tab[f3] + ((ins[30] && f3 == 3'd5) ? 1 : 0);
            e.reg_write = 1; e.alu_src = 1; e.imm = iI; e.alu_ctrl = 4'(ac);
            e.word_op = (op == 7'b0011011);
         end
         K_LOAD:  begin e.reg_write = 1; e.mem_read = 1; e.alu_src = 1; e.imm = iI; e.result_src = 2'b01; end
         K_STORE: begin e.mem_write = 1; e.alu_src = 1; e.imm = iS; end
         K_LUI:   begin e.reg_write = 1; e.alu_src = 1; e.imm = iU; e.alu_ctrl = 4'd10; end
         K_AUIPC: begin e.reg_write = 1; e.alu_src = 1; e.imm = iU; e.alu_ctrl = 4'd11; end
         K_JAL:   begin e.reg_write = 1; e.imm = iJ; e.result_src = 2'b10; end
         K_JALR:  begin e.reg_write = 1; e.alu_src = 1; e.imm = iI; e.result_src = 2'b10; end
         K_BR:    e.imm = iB;
         default: e.illegal = 1;
      endcase
      if (ins[11:7] == 5'd0) e.reg_write = 0;
      case (f3)
         3'd0: taken = (a == b);
         3'd1: taken = (a != b);
         3'd4: taken = (longint'(a) < longint'(b));
         3'd5: taken = (longint'(a) >= longint'(b));
         3'd6: taken = (a < b);
         3'd7: taken = (a >= b);
         default: taken = 0;
      endcase
      pcsrc = (k == K_BR) && taken;
      jal   = (k == K_JAL) || (k == K_JALR);
      tgt   = (k == K_JALR) ? ((a + iI) & ~64'd1) : (k == K_JAL) ? (pc + iJ) : (pc + iB);
   endfunction

   task automatic wb_write(input logic [4:0] r, input logic [63:0] v);
      RegWriteW = 1'b1; RdW = r; ResultW = v;
      @(posedge clk); #1;
      RegWriteW = 1'b0; RdW = 5'd0; ResultW = 64'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; InstrD = 32'd0; PCD = 64'd0; PCPlus4D = 64'd4;
      StallD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RdW = 5'd0; ResultW = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (act !== '0) begin n_fail++; $display("FAIL reset_e: got %h want 0", act); end
      n_cmp++; if ({PCSrcD, JalD, PCTargetD} !== 66'd0) begin n_fail++;
         $display("FAIL reset_comb: got %b %b %h want 0 0 0", PCSrcD, JalD, PCTargetD); end
      rst = 1'b0;
      InstrD = 32'h0050_0093;
      #1;
      n_cmp++; if (act !== '0) begin n_fail++; $display("FAIL release_e: got %h want 0", act); end
      @(posedge clk); #1;
      n_cmp++; if (ImmExtE !== 64'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", ImmExtE); end
      n_cmp++; if (RdE !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", RdE); end
      n_cmp++; if ({RegWriteE, ALUSrcE} !== 2'b11) begin n_fail++;
         $display("FAIL addi_ctl: got %b%b want 11", RegWriteE, ALUSrcE); end
   endtask

   task automatic test_branch();
      wb_write(5'd2, 64'd7);
      wb_write(5'd3, 64'd7);
      PCD = 64'h40; PCPlus4D = 64'h44;
      InstrD = enc_b(32'd16, 5'd3, 5'd2, 3'b000);
      #1;
      n_cmp++; if (PCSrcD !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", PCSrcD); end
      n_cmp++; if (PCTargetD !== 64'h50) begin n_fail++; $display("FAIL beq_target: got %h want 50", PCTargetD); end
      InstrD = enc_b(32'd16, 5'd3, 5'd2, 3'b001);
      #1;
      n_cmp++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL bne_taken: got %b want 0", PCSrcD); end
   endtask

   task automatic test_jump();
      PCD = 64'h100; PCPlus4D = 64'h104;
      InstrD = enc_j(32'h20, 5'd1);
      #1;
      n_cmp++; if ({JalD, PCTargetD} !== {1'b1, 64'h120}) begin n_fail++;
         $display("FAIL jal_redirect: got %b %h want 1 120", JalD, PCTargetD); end
      @(posedge clk); #1;
      n_cmp++; if (ResultSrcE !== 2'b10) begin n_fail++; $display("FAIL jal_rsrc: got %b want 10", ResultSrcE); end
      wb_write(5'd2, 64'h201);
      InstrD = enc_i(32'd5, 5'd2, 3'b000, 5'd0, 7'b1100111);
      #1;
      n_cmp++; if ({JalD, PCTargetD} !== {1'b1, 64'h206}) begin n_fail++;
         $display("FAIL jalr_redirect: got %b %h want 1 206", JalD, PCTargetD); end
      @(posedge clk); #1;
      n_cmp++; if ({RegWriteE, ResultSrcE} !== 3'b010) begin n_fail++;
         $display("FAIL jalr_x0: got %b %b want 0 10", RegWriteE, ResultSrcE); end
   endtask

   task automatic test_bypass();
      InstrD = enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd1, 7'b0110011);
      RegWriteW = 1'b1; RdW = 5'd5; ResultW = 64'hAB;
      @(posedge clk); #1;
      RegWriteW = 1'b0;
      n_cmp++; if (RD1E !== 64'hAB) begin n_fail++; $display("FAIL bypass_rd1: got %h want ab", RD1E); end
      @(posedge clk); #1;
      n_cmp++; if (RD1E !== 64'hAB) begin n_fail++; $display("FAIL stored_rd1: got %h want ab", RD1E); end
      InstrD = 32'h0050_0093;
      RegWriteW = 1'b1; RdW = 5'd0; ResultW = 64'h123;
      @(posedge clk); #1;
      RegWriteW = 1'b0;
      n_cmp++; if (RD1E !== 64'd0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", RD1E); end
      @(posedge clk); #1;
      n_cmp++; if (RD1E !== 64'd0) begin n_fail++; $display("FAIL x0_stored: got %h want 0", RD1E); end
   endtask

   task automatic test_stall_flush();
      InstrD = 32'h0050_0093; PCD = 64'h300; PCPlus4D = 64'h304;
      #1;
      model(InstrD, PCD, PCPlus4D, x_pcsrc, x_jal, x_tgt, exp_e);
      @(posedge clk); #1;
      n_cmp++; if (act !== exp_e) begin n_fail++; $display("FAIL pre_stall: got %h want %h", act, exp_e); end
      StallD = 1'b1;
      for (int c = 0; c < 2; c++) begin
         InstrD = $urandom; PCD = {$urandom, $urandom}; PCPlus4D = PCD + 64'd4;
         @(posedge clk); #1;
         n_cmp++; if (act !== exp_e) begin n_fail++; $display("FAIL stall_hold: got %h want %h", act, exp_e); end
      end
      FlushE = 1'b1;
      InstrD = enc_r(7'd0, 5'd2, 5'd1, 3'b011, 5'd0, 7'b0100011);
      @(posedge clk); #1;
      n_cmp++; if ({RegWriteE, MemWriteE} !== 2'b00) begin n_fail++;
         $display("FAIL flush_ctl: got %b%b want 00", RegWriteE, MemWriteE); end
      n_cmp++; if (act !== '0) begin n_fail++; $display("FAIL flush_all: got %h want 0", act); end
      FlushE = 1'b0; StallD = 1'b0;
   endtask

   task automatic test_signed_branch();
      wb_write(5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
      wb_write(5'd7, 64'd1);
      PCD = 64'h80; PCPlus4D = 64'h84;
      InstrD = enc_b(32'd8, 5'd7, 5'd6, 3'b100);
      #1;
      n_cmp++; if (PCSrcD !== 1'b1) begin n_fail++; $display("FAIL blt: got %b want 1", PCSrcD); end
      InstrD = enc_b(32'd8, 5'd7, 5'd6, 3'b110);
      #1;
      n_cmp++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL bltu: got %b want 0", PCSrcD); end
      InstrD = 32'h0000_007F;
      #1;
      n_cmp++; if ({PCSrcD, JalD} !== 2'b00) begin n_fail++;
         $display("FAIL illegal_redirect: got %b%b want 00", PCSrcD, JalD); end
      @(posedge clk); #1;
      n_cmp++; if ({IllegalE, RegWriteE, MemWriteE, MemReadE} !== 4'b1000) begin n_fail++;
         $display("FAIL illegal_e: got %b%b%b%b want 1000", IllegalE, RegWriteE, MemWriteE, MemReadE); end
   endtask

   task automatic test_random();
      logic [6:0]  ops [11] = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011,
                                7'b0100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                7'b1100011};
      logic [31:0] ins;
      e_t          dec, nxt;
      int          pick;
      FlushE = 1'b1;
      @(posedge clk); #1;
      FlushE = 1'b0;
      exp_e = '0;
      for (int i = 1; i < 8; i++) wb_write(5'(i), {$urandom, $urandom});
      for (int it = 0; it < 400; it++) begin
         ins = $urandom;
         pick = $urandom_range(0, 11);
         ins[6:0]   = (pick == 11) ? 7'($urandom) : ops[pick];
         ins[11:7]  = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         if (pick == 10 && $urandom_range(0, 3) == 0) ins[24:20] = ins[19:15];
         InstrD = ins; PCD = {$urandom, $urandom}; PCPlus4D = PCD + 64'd4;
         RegWriteW = ($urandom_range(0, 2) != 0);
         RdW = 5'($urandom_range(0, 7));
         ResultW = {$urandom, $urandom};
         StallD = ($urandom_range(0, 4) == 0);
         FlushE = ($urandom_range(0, 7) == 0);
         #1;
         model(InstrD, PCD, PCPlus4D, x_pcsrc, x_jal, x_tgt, dec);
         n_cmp++; if ({PCSrcD, JalD, PCTargetD} !== {x_pcsrc, x_jal, x_tgt}) begin n_fail++;
            $display("FAIL rand_redirect[%0d] instr=%h: got %b %b %h want %b %b %h", it, InstrD,
                     PCSrcD, JalD, PCTargetD, x_pcsrc, x_jal, x_tgt); end
         nxt = FlushE ? e_t'(0) : (StallD ? exp_e : dec);
         @(posedge clk); #1;
         exp_e = nxt;
         n_cmp++; if (act !== exp_e) begin n_fail++;
            $display("FAIL rand_idex[%0d] instr=%h: got %h want %h", it, InstrD, act, exp_e); end
      end
      RegWriteW = 1'b0; StallD = 1'b0; FlushE = 1'b0;
   endtask

   task automatic test_async_reset();
      InstrD = 32'h0050_0093;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (act !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", act); end
      @(posedge clk); #1;
      rst = 1'b0;
      InstrD = enc_r(7'd0, 5'd4, 5'd3, 3'd0, 5'd1, 7'b0110011);
      @(posedge clk); #1;
      n_cmp++; if ({RD1E, RD2E} !== 128'd0) begin n_fail++;
         $display("FAIL rf_cleared: got %h %h want 0 0", RD1E, RD2E); end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_jump();
      test_bypass();
      test_stall_flush();
      test_signed_branch();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV64I pipeline decode stage. Consumes the IF/ID outputs of fetch (InstrD, PCD, PCPlus4D) and holds the 32x64 register file.
- Resolves branches and jumps in decode and returns PCSrcD, JalD and PCTargetD to fetch.
- Launches decoded operands and control into the ID/EX pipeline register feeding execute.

Parameters:
- XLEN, 64, datapath width
- NREG, 32, register count; x0 is hardwired to zero

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- InstrD  input  32  instruction from IF/ID
- PCD  input  XLEN  PC of InstrD
- PCPlus4D  input  XLEN  PCD+4
- StallD  input  1  hold the ID/EX register (hazard unit)
- FlushE  input  1  load a bubble into the ID/EX register
- RegWriteW  input  1  writeback enable
- RdW  input  5  writeback destination
- ResultW  input  XLEN  writeback data
- PCSrcD  output  1  taken conditional branch (combinational)
- JalD  output  1  JAL or JALR in decode (combinational)
- PCTargetD  output  XLEN  redirect target (combinational)
- RegWriteE, MemReadE, MemWriteE, ALUSrcE, WordOpE  output  1 each  registered control
- ResultSrcE  output  2  00 ALU, 01 memory, 10 PC+4
- ALUCtrlE  output  4  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 10 pass imm (LUI), 11 PC+imm (AUIPC)
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  XLEN each  registered operands
- Rs1E, Rs2E, RdE  output  5 each  registered register indices
- IllegalE  output  1  registered unsupported-opcode flag

Behaviour:
- Reset (async, rst=1): all register-file entries, all E outputs and all ID/EX state cleared to 0. Combinational outputs follow the decoded InstrD.
- Register file:
  - Written on the rising clk edge when RegWriteW=1 and RdW!=0. Writes to x0 are ignored.
  - Reads are combinational. Read of x0 returns 0.
  - Write-through bypass: if RegWriteW=1, RdW!=0 and RdW equals rs1 or rs2, the read returns ResultW in the same cycle.
- Immediates, sign-extended to XLEN: I, S, B, U, J formats. U-format is sign-extended from bit 31.
- Branch resolution, combinational, using bypassed RD1/RD2:
  - Opcode 1100011, funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU. Signed compares for BLT/BGE, unsigned for BLTU/BGEU.
  - PCSrcD=1 iff the branch condition holds.
  - Any other funct3 under this opcode: PCSrcD=0 and illegal.
- Jumps:
  - JAL (1101111): JalD=1, PCTargetD=PCD+immJ.
  - JALR (1100111, funct3 000): JalD=1, PCTargetD=(RD1+immI) with bit0 cleared.
  - For branches, PCTargetD=PCD+immB.
  - Neither branch nor jump: PCSrcD=0, JalD=0, PCTargetD=PCD+immB (don't-care value, but defined).
- Decoded classes:
  - R, I-ALU, load (MemReadE=1, ResultSrcE=01), store (MemWriteE=1, RegWriteE=0), LUI, AUIPC, JAL/JALR (ResultSrcE=10, RegWriteE=1).
  - OP-32/OP-IMM-32 set WordOpE=1.
  - rd=0 forces RegWriteE=0.
- Illegal: any other opcode drives all enables to 0 and IllegalE=1. An illegal instruction never redirects fetch.
- ID/EX register, on the rising clk edge:
  - FlushE=1: bubble. All control outputs 0, ALUCtrlE=0, IllegalE=0; data fields are don't-care and cleared to 0.
  - Else StallD=1: hold all E outputs.
  - Else: load decoded values.
  - FlushE has priority over StallD.
- Latency: redirect is 0 cycles (combinational from IF/ID). E outputs are 1 cycle.
- Simultaneous writeback and read of the same register: the new value is used both for the branch compare and for the latched RD1E/RD2E.
- rst asserted mid-operation clears all state immediately. The register file is not preserved.

Test Plan:
- Reset then release; no writeback -> every E output is 0; ADDI x1,x0,5 (0x00500093) latched next edge -> ImmExtE=5, RdE=1, RegWriteE=1, ALUSrcE=1.
- Write x2=7 and x3=7 via WB, then BEQ x2,x3,+16 at PCD=0x40 -> PCSrcD=1, PCTargetD=0x50; BNE with the same operands -> PCSrcD=0.
- JAL x1,+0x20 at PCD=0x100 -> JalD=1, PCTargetD=0x120, ResultSrcE=10; JALR x0,5(x2) with x2=0x201 -> PCTargetD=0x206, RegWriteE=0.
- WB writes x5=0xAB in the same cycle InstrD reads x5 -> RD1E=0xAB next edge; WB write to x0 -> x0 still reads 0.
- StallD=1 for 2 cycles while InstrD changes -> E outputs unchanged; FlushE=1 and StallD=1 together -> bubble (RegWriteE=0, MemWriteE=0).
- BLT x6,x7 with x6=-1, x7=1 -> PCSrcD=1; BLTU with the same values -> PCSrcD=0; opcode 0x7F -> IllegalE=1 and no redirect.
